// File: rtl/interval_alarm.sv
// interval_alarm: programmable countdown alarm driven by system timebase pulses.
//
// A run is started by an accepted start: start=1, stop=0 and period!=0.
// period, unit_sel and periodic are captured at that moment. Each qualified
// tick of the selected timebase decrements the remaining count. When a tick
// arrives with one tick left, the alarm expires:
//   - periodic mode reloads the count and keeps running;
//   - one-shot mode returns to idle.
// Every expiry raises a sticky irq, which is cleared by irq_ack. Expiries
// that arrive while irq is still pending are counted in missed_cnt.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   usecond_pulse   1-cycle tick every microsecond
//   msecond_pulse   1-cycle tick every millisecond
//   second_pulse    1-cycle tick every second
//   start, stop     1-cycle load-and-run / halt requests (stop wins)
//   period          ticks per expiry, captured on an accepted start
//   unit_sel        tick source: 0=us, 1=ms, 2=s, 3=every clk
//   periodic        1=auto-reload, 0=one-shot, captured on an accepted start
//   irq_ack         clears irq and missed_cnt
//   busy            high while running
//   remaining       ticks left before expiry
//   expire_pulse    1-cycle strobe per expiry
//   irq             sticky expiry flag
//   missed_cnt      saturating count of expiries while irq was pending
module interval_alarm #(
    parameter int unsigned CNTR_WIDTH = 16,
    parameter int unsigned MISS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  usecond_pulse,
    input  logic                  msecond_pulse,
    input  logic                  second_pulse,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNTR_WIDTH-1:0] period,
    input  logic [1:0]            unit_sel,
    input  logic                  periodic,
    input  logic                  irq_ack,
    output logic                  busy,
    output logic [CNTR_WIDTH-1:0] remaining,
    output logic                  expire_pulse,
    output logic                  irq,
    output logic [MISS_WIDTH-1:0] missed_cnt
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q;
    logic [CNTR_WIDTH-1:0] reload_q;
    logic [1:0]            unit_q;
    logic                  periodic_q;

    logic accept;
    logic tick;
    logic qual_tick;
    logic expiry;

    always_comb begin
        accept = start && !stop && (period != '0);

        // The tick source comes from the captured unit, not the live input.
        tick = 1'b0;
        case (unit_q)
            2'd0:    tick = usecond_pulse;
            2'd1:    tick = msecond_pulse;
            2'd2:    tick = second_pulse;
            default: tick = 1'b1;
        endcase

        // A load or halt takes priority over a tick in the same cycle.
        qual_tick = (state_q == StRun) && !accept && !stop && tick;
        expiry    = qual_tick && (remaining == CNTR_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            reload_q     <= '0;
            unit_q       <= '0;
            periodic_q   <= 1'b0;
            busy         <= 1'b0;
            remaining    <= '0;
            expire_pulse <= 1'b0;
            irq          <= 1'b0;
            missed_cnt   <= '0;
        end else begin
            expire_pulse <= expiry;

            if (stop) begin
                state_q   <= StIdle;
                busy      <= 1'b0;
                remaining <= '0;
            end else if (accept) begin
                reload_q   <= period;
                unit_q     <= unit_sel;
                periodic_q <= periodic;
                state_q    <= StRun;
                busy       <= 1'b1;
                remaining  <= period;
            end else if (qual_tick) begin
                if (remaining == CNTR_WIDTH'(1)) begin
                    if (periodic_q) begin
                        // Reloading on the expiring tick gives exactly reload_q
                        // ticks per period.
                        remaining <= reload_q;
                    end else begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end
                end else begin
                    remaining <= remaining - CNTR_WIDTH'(1);
                end
            end

            // An expiry sets irq even when it coincides with an ack.
            if (expiry) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end

            // An expiry that coincides with an ack becomes the new irq, not a miss.
            if (irq_ack) begin
                missed_cnt <= '0;
            end else if (expiry && irq && (missed_cnt != {MISS_WIDTH{1'b1}})) begin
                missed_cnt <= missed_cnt + MISS_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_interval_alarm.sv
module tb_interval_alarm;

    localparam int unsigned CW = 16;
    localparam int unsigned MW = 8;
    localparam int MISS_MAX = (1 << MW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          usecond_pulse, msecond_pulse, second_pulse;
    logic          start, stop, periodic, irq_ack;
    logic [CW-1:0] period;
    logic [1:0]    unit_sel;
    logic          busy, expire_pulse, irq;
    logic [CW-1:0] remaining;
    logic [MW-1:0] missed_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    interval_alarm #(.CNTR_WIDTH(CW), .MISS_WIDTH(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .usecond_pulse(usecond_pulse),
        .msecond_pulse(msecond_pulse),
        .second_pulse (second_pulse),
        .start        (start),
        .stop         (stop),
        .period       (period),
        .unit_sel     (unit_sel),
        .periodic     (periodic),
        .irq_ack      (irq_ack),
        .busy         (busy),
        .remaining    (remaining),
        .expire_pulse (expire_pulse),
        .irq          (irq),
        .missed_cnt   (missed_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a run is described by its reload value and the number
    // of ticks consumed since the load. remaining follows arithmetically.
    bit m_run, m_per, m_exp, m_irq;
    int m_reload, m_unit, m_ticks, m_miss;

    function automatic int m_remaining();
        if (!m_run) return 0;
        return m_reload - (m_ticks % m_reload);
    endfunction

    task automatic model_step();
        bit acc, tk, q, ex;
        acc = start && !stop && (period != 0);
        tk  = (m_unit == 0) ? usecond_pulse : (m_unit == 1) ? msecond_pulse :
              (m_unit == 2) ? second_pulse : 1'b1;
        q   = m_run && !acc && !stop && tk;
        ex  = q && (((m_ticks + 1) % m_reload) == 0);
        if (rst) begin
            m_run = 0; m_per = 0; m_exp = 0; m_irq = 0;
            m_reload = 0; m_unit = 0; m_ticks = 0; m_miss = 0;
        end else begin
            m_exp = ex;
            if (irq_ack) m_miss = 0;
            else if (ex && m_irq && m_miss < MISS_MAX) m_miss++;
            if (ex) m_irq = 1;
            else if (irq_ack) m_irq = 0;
            if (stop) begin
                m_run = 0; m_ticks = 0;
            end else if (acc) begin
                m_run = 1; m_reload = int'(period); m_unit = int'(unit_sel);
                m_per = periodic; m_ticks = 0;
            end else if (q) begin
                m_ticks++;
                if (ex && !m_per) m_run = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; usecond_pulse = 0; msecond_pulse = 0; second_pulse = 0;
        start = 0; stop = 0; period = '0; unit_sel = 2'd0; periodic = 0; irq_ack = 0;
    endtask

    // One clock: model consumes the pre-edge inputs, outputs sampled 1 after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit       rst, start, stop, periodic, ack, us, ms, s;
        int       period;
        int       unit;
        bit       e_busy, e_exp, e_irq;
        int       e_rem, e_miss;
    } vec_t;

    function automatic vec_t mk(bit r, bit st, bit sp, int per, int u, bit pd, bit ak,
                                bit us, bit ms, bit s,
                                bit eb, int er, bit ee, bit ei, int em);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.period = per; v.unit = u;
        v.periodic = pd; v.ack = ak; v.us = us; v.ms = ms; v.s = s;
        v.e_busy = eb; v.e_rem = er; v.e_exp = ee; v.e_irq = ei; v.e_miss = em;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        bit found;
        int gap;

        //                 rst st sp per u pd ak us ms s   busy rem exp irq miss
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0));
        // One-shot, every clock, period 5.
        vecs.push_back(mk(0, 1, 0, 5, 3, 0, 0, 0, 0, 0,   1, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0));
        // Stop beats a same-cycle start; then a start beats a same-cycle tick.
        vecs.push_back(mk(0, 1, 0, 7, 3, 1, 0, 0, 0, 0,   1, 7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 9, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9, 3, 1, 0, 0, 0, 0,   1, 9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 8, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        // A zero-period start is ignored.
        vecs.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        // Reset at remaining==1 with a tick present: no expiry.
        vecs.push_back(mk(0, 1, 0, 2, 3, 0, 0, 0, 0, 0,   1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        // Millisecond source ignores the other pulses.
        vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0, 1, 0, 1,   1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1, 0));

        idle_inputs();
        #2;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            period = CW'(vecs[i].period); unit_sel = 2'(vecs[i].unit);
            periodic = vecs[i].periodic; irq_ack = vecs[i].ack;
            usecond_pulse = vecs[i].us; msecond_pulse = vecs[i].ms; second_pulse = vecs[i].s;
            cycle();
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("v%0d_rem", i), int'(remaining), vecs[i].e_rem);
            chk($sformatf("v%0d_exp", i), int'(expire_pulse), int'(vecs[i].e_exp));
            chk($sformatf("v%0d_irq", i), int'(irq), int'(vecs[i].e_irq));
            chk($sformatf("v%0d_miss", i), int'(missed_cnt), vecs[i].e_miss);
        end

        // Periodic, period 3, no ack: 300 expiries saturate missed_cnt.
        idle_inputs();
        rst = 1; cycle(); rst = 0;
        start = 1; period = CW'(3); unit_sel = 2'd3; periodic = 1; cycle();
        idle_inputs();
        for (int n = 1; n <= 300; n++) begin
            found = 0;
            gap = 0;
            for (int k = 0; k < 6 && !found; k++) begin
                cycle();
                gap = k + 1;
                if (expire_pulse) found = 1;
            end
            chk($sformatf("per_found_%0d", n), int'(found), 1);
            if (!found) break;
            chk($sformatf("per_gap_%0d", n), gap, 3);
            chk($sformatf("per_irq_%0d", n), int'(irq), 1);
            chk($sformatf("per_miss_%0d", n), int'(missed_cnt), (n - 1 > MISS_MAX) ? MISS_MAX : n - 1);
        end
        // Ack on the expiring tick: irq stays set, missed_cnt clears.
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            if (remaining == CW'(1)) found = 1;
            else cycle();
        end
        chk("ack_wait", int'(found), 1);
        irq_ack = 1; cycle(); irq_ack = 0;
        chk("ack_exp", int'(expire_pulse), 1);
        chk("ack_irq", int'(irq), 1);
        chk("ack_miss", int'(missed_cnt), 0);
        cycle();
        chk("ack_irq2", int'(irq), 1);
        chk("ack_rem", int'(remaining), 2);

        // Randomized run against the reference model.
        idle_inputs();
        rst = 1; cycle();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 49) == 0);
            irq_ack = ($urandom_range(0, 24) == 0);
            period = ($urandom_range(0, 9) == 0) ? CW'(0) : CW'($urandom_range(1, 7));
            unit_sel = 2'($urandom_range(0, 3));
            periodic = 1'($urandom_range(0, 1));
            usecond_pulse = ($urandom_range(0, 1) == 0);
            msecond_pulse = ($urandom_range(0, 3) == 0);
            second_pulse = ($urandom_range(0, 7) == 0);
            cycle();
            chk("rnd_busy", int'(busy), int'(m_run));
            chk("rnd_rem", int'(remaining), m_remaining());
            chk("rnd_exp", int'(expire_pulse), int'(m_exp));
            chk("rnd_irq", int'(irq), int'(m_irq));
            chk("rnd_miss", int'(missed_cnt), m_miss);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/interval_alarm.md
Name: interval_alarm

Overview:
- Consumes the timebase pulses produced by the system timer (usecond/msecond/second) and turns them into a programmable countdown alarm.
- Supports one-shot and periodic modes, with a sticky interrupt that software acknowledges.
- Counts expiries that occur while the interrupt is still pending.
- Sits between the system timer and the control/CSR logic.

Parameters:
- CNTR_WIDTH, 16: width of period, reload and remaining count.
- MISS_WIDTH, 8: width of the saturating missed-expiry counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- usecond_pulse  input  1  1-cycle tick every microsecond.
- msecond_pulse  input  1  1-cycle tick every millisecond.
- second_pulse  input  1  1-cycle tick every second.
- start  input  1  1-cycle request to load and run.
- stop  input  1  1-cycle request to halt.
- period  input  CNTR_WIDTH  tick count per expiry; sampled on accepted start.
- unit_sel  input  2  tick source: 0=us, 1=ms, 2=s, 3=every clk (test/fast mode); sampled on accepted start.
- periodic  input  1  1=auto-reload, 0=one-shot; sampled on accepted start.
- irq_ack  input  1  clears irq and missed_cnt.
- busy  output  1  high in RUN state.
- remaining  output  CNTR_WIDTH  ticks left before expiry.
- expire_pulse  output  1  1-cycle strobe per expiry.
- irq  output  1  sticky expiry flag.
- missed_cnt  output  MISS_WIDTH  expiries while irq already pending (saturating).

Behaviour:
- Reset: all outputs and internal registers are 0; state IDLE. Synchronous reset overrides all other inputs. Reset mid-run aborts with no expiry.
- States are IDLE and RUN. busy = (state==RUN), registered.
- Accepted start means start=1, stop=0 and period!=0. It latches period into the reload register and latches unit_sel and periodic. At N+1: state=RUN, remaining=period. This is legal in either state; in RUN it restarts the count.
- A start with period==0 is ignored; state and count are unchanged.
- stop=1, in any state: next cycle state=IDLE, remaining=0. stop wins over a same-cycle start. irq and missed_cnt are unaffected.
- tick is the selected pulse (or constant 1 when unit_sel=3). It is qualified only in RUN and only in cycles with no accepted start or stop; load/halt takes priority over a same-cycle tick.
- On a qualified tick with remaining>1: remaining decrements by 1 at the next cycle.
- On a qualified tick with remaining==1 (expiry at cycle M), at M+1:
  - expire_pulse=1 for exactly one cycle.
  - periodic: remaining=reload and state stays RUN, giving a period of exactly `reload` ticks with no lost tick.
  - one-shot: remaining=0 and state=IDLE.
- irq: set at M+1 on expiry. Cleared at the cycle after irq_ack=1 when no expiry coincides. If expiry and irq_ack occur in the same cycle, irq stays 1 (set wins).
- missed_cnt:
  - Increments when an expiry occurs with irq==1 and irq_ack==0, saturating at 2^MISS_WIDTH-1.
  - irq_ack=1 clears it to 0. An expiry coincident with an ack counts as the new irq, not as a miss.
- Changing period/unit_sel/periodic while RUN has no effect until the next accepted start.
- remaining never wraps; it never decrements below 1 except through expiry or stop.

Test Plan:
1. rst=1 then 0, no start -> busy=0, remaining=0, irq=0, missed_cnt=0, expire_pulse=0 indefinitely.
2. unit_sel=3, periodic=0, period=5, start at cycle 10 -> busy=1, remaining=5 at cycle 11; remaining 4,3,2,1 at cycles 12-15; expire_pulse=1, irq=1, busy=0, remaining=0 at cycle 16; no further pulses.
3. unit_sel=3, periodic=1, period=3, no ack -> expire_pulse every 3 cycles; irq stays 1; missed_cnt reads 1,2,3... after the 2nd, 3rd, 4th... expiry; with MISS_WIDTH=8 and 300 expiries, missed_cnt=255. Assert irq_ack in the same cycle as an expiry -> irq stays 1, missed_cnt=0 next cycle.
4. unit_sel=1, period=2, usecond and second pulses toggling freely -> remaining changes only on msecond_pulse; expiry 1 cycle after the 2nd msecond_pulse.
5. In RUN with remaining=7: start (period=9) and stop in the same cycle -> IDLE, remaining=0. Then a start coincident with a selected tick -> remaining=9, no decrement that cycle.
6. Mid-run rst=1 at remaining=1 with tick present -> no expire_pulse, all outputs 0 next cycle. start with period=0 in IDLE -> busy stays 0.
